// File: rtl/serial_digit_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// FSM state encoding and slice-counter sizing.
package serial_digit_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice counter never narrower than one bit, even for a single-slice adder.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_digit_adder_digit_adder.sv
// DIGIT-bit combinational ripple-carry adder.
// Used as the single per-cycle slice adder of serial_digit_adder.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1]   = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign cout = carry[DIGIT];

endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial adder: adds a + b + cin one DIGIT slice per clock, LSB slice first.
// Optional subtract mode is enabled with the SERIAL_DIGIT_ADDER_SUB_EN macro.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one slice added per cycle, N cycles
// DONE  | out_valid high, result held until out_ready
module serial_digit_adder
    import serial_digit_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(WIDTH, DIGIT);

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("serial_digit_adder: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             last;
    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [WIDTH-1:0] sum_shift;

`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    // Two's-complement subtract: a + ~b + ~cin, so cout=1 means no borrow.
    assign b_in   = sub ? ~b : b;
    assign cin_in = cin ^ sub;
`else
    assign b_in   = b;
    assign cin_in = cin;
`endif

    assign last = (cnt == CW'(N - 1));

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_r[DIGIT-1:0]),
        .b    (b_r[DIGIT-1:0]),
        .cin  (carry_r),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Operands shift right each slice; results enter sum from the MSB end.
    if (N == 1) begin : g_single
        assign a_shift   = '0;
        assign b_shift   = '0;
        assign sum_shift = slice_sum;
    end else begin : g_multi
        assign a_shift   = {{DIGIT{1'b0}}, a_r[WIDTH-1:DIGIT]};
        assign b_shift   = {{DIGIT{1'b0}}, b_r[WIDTH-1:DIGIT]};
        assign sum_shift = {slice_sum, sum_r[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b_in;
                        carry_r <= cin_in;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    a_r     <= a_shift;
                    b_r     <= b_shift;
                    sum_r   <= sum_shift;
                    carry_r <= slice_cout;
                    cnt     <= last ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = carry_r;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Self-checking bench for serial_digit_adder: four instances of different geometry,
// table vectors, backpressure, mid-operation reset and a randomised scoreboard run.
module tb_serial_digit_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    // unit 0: WIDTH=8 DIGIT=4
    logic       iv0, ir0, cin0, ov0, or0, co0;
    logic [7:0] a0, b0, s0;
    // unit 1: WIDTH=8 DIGIT=1
    logic       iv1, ir1, cin1, ov1, or1, co1;
    logic [7:0] a1, b1, s1;
    // unit 2: WIDTH=32 DIGIT=4
    logic        iv2, ir2, cin2, ov2, or2, co2;
    logic [31:0] a2, b2, s2;
    // unit 3: WIDTH=16 DIGIT=4
    logic        iv3, ir3, cin3, ov3, or3, co3;
    logic [15:0] a3, b3, s3;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    logic sb0, sb1, sb2, sb3;
`endif

    serial_digit_adder #(.WIDTH(8), .DIGIT(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .cin(cin0),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        .sub(sb0),
`endif
        .out_valid(ov0), .out_ready(or0), .sum(s0), .cout(co0));

    serial_digit_adder #(.WIDTH(8), .DIGIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        .sub(sb1),
`endif
        .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1));

    serial_digit_adder #(.WIDTH(32), .DIGIT(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(cin2),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        .sub(sb2),
`endif
        .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2));

    serial_digit_adder #(.WIDTH(16), .DIGIT(4)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3), .cin(cin3),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        .sub(sb3),
`endif
        .out_valid(ov3), .out_ready(or3), .sum(s3), .cout(co3));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       c;
    } vec_t;

    vec_t        tbl [8];
    logic [16:0] exp_q [$];

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int u, input logic v, input logic [31:0] av,
                          input logic [31:0] bv, input logic c);
        case (u)
            0: begin iv0 = v; a0 = av[7:0];  b0 = bv[7:0];  cin0 = c; end
            1: begin iv1 = v; a1 = av[7:0];  b1 = bv[7:0];  cin1 = c; end
            2: begin iv2 = v; a2 = av;       b2 = bv;       cin2 = c; end
            default: begin iv3 = v; a3 = av[15:0]; b3 = bv[15:0]; cin3 = c; end
        endcase
    endtask

    task automatic set_ordy(input int u, input logic v);
        case (u)
            0: or0 = v;
            1: or1 = v;
            2: or2 = v;
            default: or3 = v;
        endcase
    endtask

    function automatic logic get_ov(input int u);
        case (u)
            0: return ov0;
            1: return ov1;
            2: return ov2;
            default: return ov3;
        endcase
    endfunction

    function automatic logic get_ir(input int u);
        case (u)
            0: return ir0;
            1: return ir1;
            2: return ir2;
            default: return ir3;
        endcase
    endfunction

    function automatic logic get_co(input int u);
        case (u)
            0: return co0;
            1: return co1;
            2: return co2;
            default: return co3;
        endcase
    endfunction

    function automatic logic [31:0] get_sum(input int u);
        case (u)
            0: return {24'd0, s0};
            1: return {24'd0, s1};
            2: return s2;
            default: return {16'd0, s3};
        endcase
    endfunction

    // One full transaction: accept, count latency, optional hold under backpressure, release.
    task automatic run_op(input int u, input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic c, input logic [31:0] es, input logic ec, input int lat,
                          input int hold);
        int   k;
        logic ir_seen;
        logic held_bad;
        @(negedge clk);
        check({tag, " in_ready before accept"}, get_ir(u), 1'b1);
        set_in(u, 1'b1, av, bv, c);
        @(negedge clk);
        set_in(u, 1'b0, ~av, $urandom, ~c);
        k = 0;
        ir_seen = 1'b0;
        while (!get_ov(u) && k < 64) begin
            if (get_ir(u)) ir_seen = 1'b1;
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, k, lat);
        check({tag, " in_ready during run"}, ir_seen, 1'b0);
        check({tag, " sum"}, get_sum(u), es);
        check({tag, " cout"}, get_co(u), ec);
        if (hold > 0) begin
            held_bad = 1'b0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!get_ov(u) || get_ir(u) || get_sum(u) !== es || get_co(u) !== ec)
                    held_bad = 1'b1;
            end
            check({tag, " held under backpressure"}, held_bad, 1'b0);
        end
        set_ordy(u, 1'b1);
        @(negedge clk);
        set_ordy(u, 1'b0);
        check({tag, " out_valid after handshake"}, get_ov(u), 1'b0);
        check({tag, " in_ready after handshake"}, get_ir(u), 1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 4; u++) begin
            set_in(u, 1'b0, 32'd0, 32'd0, 1'b0);
            set_ordy(u, 1'b0);
        end
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        sb0 = 1'b0; sb1 = 1'b0; sb2 = 1'b0; sb3 = 1'b0;
`endif
        tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[1] = '{8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        tbl[6] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        tbl[7] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

        repeat (2) @(negedge clk);
        check("reset in_ready", ir2, 1'b1);
        check("reset out_valid", ov2, 1'b0);
        check("reset sum", s2, 32'd0);
        check("reset cout", co2, 1'b0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_op(0, $sformatf("w8d4 vec%0d", i), {24'd0, tbl[i].a}, {24'd0, tbl[i].b},
                   tbl[i].cin, {24'd0, tbl[i].s}, tbl[i].c, 2, 0);
            run_op(1, $sformatf("w8d1 vec%0d", i), {24'd0, tbl[i].a}, {24'd0, tbl[i].b},
                   tbl[i].cin, {24'd0, tbl[i].s}, tbl[i].c, 8, 0);
        end

        run_op(0, "backpressure", 32'hA5, 32'h5A, 1'b1, 32'h00, 1'b1, 2, 5);

        // Reset during the fourth slice of a 32-bit operation.
        @(negedge clk);
        set_in(2, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
        @(negedge clk);
        set_in(2, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun reset out_valid", ov2, 1'b0);
        check("midrun reset sum", s2, 32'd0);
        check("midrun reset cout", co2, 1'b0);
        check("midrun reset in_ready", ir2, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2, "after reset 1+2", 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 8, 0);
        run_op(2, "w32 carry chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b1, 8, 0);

`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        sb0 = 1'b1;
        run_op(0, "sub 5-7", 32'h05, 32'h07, 1'b0, 32'hFE, 1'b0, 2, 0);
        run_op(0, "sub 7-5", 32'h07, 32'h05, 1'b0, 32'h02, 1'b1, 2, 0);
        run_op(0, "sub 7-5-1", 32'h07, 32'h05, 1'b1, 32'h01, 1'b1, 2, 0);
        sb0 = 1'b0;
`endif

        fork
            begin : driver
                logic [15:0] ra, rb;
                logic        rc, rs;
                logic [16:0] ex;
                for (int i = 0; i < 1000; i++) begin
                    int w;
                    w = 0;
                    while (!ir3 && w < 100) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 100) begin
                        check("rand in_ready timeout", 1'b0, 1'b1);
                        break;
                    end
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'b0;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
                    rs = 1'($urandom_range(0, 1));
                    sb3 = rs;
`endif
                    if (rs) begin
                        ex[15:0] = ra - rb - 16'(rc);
                        ex[16]   = ({1'b0, ra} >= ({1'b0, rb} + 17'(rc)));
                    end else begin
                        ex = {1'b0, ra} + {1'b0, rb} + 17'(rc);
                    end
                    exp_q.push_back(ex);
                    iv3 = 1'b1; a3 = ra; b3 = rb; cin3 = rc;
                    @(negedge clk);
                    iv3 = 1'b0; a3 = 16'($urandom); b3 = 16'($urandom);
                    cin3 = 1'($urandom_range(0, 1));
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
                    sb3 = ~rs;
`endif
                end
            end
            begin : monitor
                int          got;
                int          cyc;
                logic [16:0] ex;
                got = 0;
                cyc = 0;
                while (got < 1000 && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    or3 = ($urandom_range(0, 3) != 0);
                    if (ov3 && or3) begin
                        if (exp_q.size() == 0) begin
                            check("rand unexpected result", 1'b1, 1'b0);
                        end else begin
                            ex = exp_q.pop_front();
                            check("rand sum", {17'd0, s3}, {17'd0, ex[15:0]});
                            check("rand cout", co3, ex[16]);
                        end
                        got++;
                    end
                end
                or3 = 1'b0;
                if (got < 1000) check("rand result count", got, 1000);
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
